// File: rtl/fetch_pc_predict.sv
// Instruction-fetch front end: PC register plus a direct-mapped BTB/BHT with
// 2-bit saturating counters. The prediction is looked up combinationally from the current PC.
module fetch_pc_predict #(
  parameter int ADDR_BIT = 12,
  parameter int IDX_BIT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                redirect,
  input  logic [ADDR_BIT-1:0] redirect_pc,
  input  logic                upd_valid,
  input  logic [ADDR_BIT-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_BIT-1:0] upd_target,
  input  logic [1:0]          upd_bht_state,
  output logic [ADDR_BIT-1:0] pc,
  output logic [ADDR_BIT-1:0] pc_4,
  output logic [ADDR_BIT-1:0] pc_guessed,
  output logic [1:0]          bht_state
);

  localparam int TAG_BIT = ADDR_BIT - IDX_BIT - 2;
  localparam int ENTRIES = 1 << IDX_BIT;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cnt_e;

  logic [ADDR_BIT-1:0] r_pc;
  logic                r_valid  [ENTRIES];
  logic [TAG_BIT-1:0]  r_tag    [ENTRIES];
  logic [ADDR_BIT-1:0] r_target [ENTRIES];
  cnt_e                r_cnt    [ENTRIES];

  logic [IDX_BIT-1:0]  w_idx;
  logic [TAG_BIT-1:0]  w_tag;
  logic                w_hit;
  logic                w_pred_taken;
  logic [ADDR_BIT-1:0] w_pc_4;
  logic [ADDR_BIT-1:0] w_next_pc;
  logic [IDX_BIT-1:0]  w_upd_idx;
  logic [TAG_BIT-1:0]  w_upd_tag;
  logic                w_upd_hit;
  logic [1:0]          w_unused;

  function automatic cnt_e sat_cnt(input cnt_e s, input logic taken);
    if (taken) sat_cnt = (s == STRONG_T)  ? STRONG_T  : cnt_e'(s + 2'd1);
    else       sat_cnt = (s == STRONG_NT) ? STRONG_NT : cnt_e'(s - 2'd1);
  endfunction

  // Lookup uses the registered table, so an update in this cycle is seen next cycle.
  assign w_idx        = r_pc[IDX_BIT+1:2];
  assign w_tag        = r_pc[ADDR_BIT-1:IDX_BIT+2];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred_taken = w_hit && r_cnt[w_idx][1];
  assign w_pc_4       = r_pc + ADDR_BIT'(4);

  assign w_upd_idx = upd_pc[IDX_BIT+1:2];
  assign w_upd_tag = upd_pc[ADDR_BIT-1:IDX_BIT+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_unused  = upd_pc[1:0];

  always_comb begin
    w_next_pc = w_pred_taken ? r_target[w_idx] : w_pc_4;
    if (redirect)  w_next_pc = redirect_pc;
    else if (!en)  w_next_pc = r_pc;
  end

  assign pc         = r_pc;
  assign pc_4       = w_pc_4;
  assign pc_guessed = w_pred_taken ? r_target[w_idx] : w_pc_4;
  assign bht_state  = w_hit ? r_cnt[w_idx] : STRONG_NT;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= '0;
    else        r_pc <= w_next_pc;
  end

  // NOTE: the table is reset explicitly because a reset must invalidate every entry at once;
  // this makes it flops rather than a RAM macro, which is fine at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= STRONG_NT;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        // Train from the state carried down the pipe, not the live entry.
        r_cnt[w_upd_idx] <= sat_cnt(cnt_e'(upd_bht_state), upd_taken);
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_cnt[w_upd_idx]    <= WEAK_T;
      end
    end
  end

endmodule
